// File: rtl/morse_keyer.sv
// morse_keyer: takes one ASCII character per valid/ready handshake and keys
// it out as Morse code on key_out, timed in dot units of UNIT_CYCLES clocks.
// Letters A-Z and digits 0-9 are keyed. Space (0x20) inserts a 4-unit
// silence, which follows the 3-unit letter gap to form a word gap. 8'hFF ends
// the message and makes done sticky. Any other byte produces a one-cycle err
// pulse and is dropped.
// Optional feature: define LOWER_CASE_EN to key 'a'-'z' with the uppercase
// codes. When it is not defined, lowercase bytes are treated as unsupported.
module morse_keyer #(
    parameter int CLK_PERIOD_NS = 20,
    parameter int T_DOT_NS      = 1000,
    parameter int UNIT_CYCLES   = T_DOT_NS / CLK_PERIOD_NS
) (
    input  logic       in_clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       key_out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int            CW        = $clog2(UNIT_CYCLES);
    localparam logic [CW-1:0] UNIT_LAST = CW'(UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MARK,
        S_SPACE,
        S_LGAP,
        S_WGAP,
        S_DONE
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   unit_cnt_reg;   // clocks within the current dot unit
    logic [2:0]      unit_num_reg;   // whole units elapsed in the current phase
    logic [2:0]      elem_idx_reg;   // element being keyed, counts down to 0
    logic [7:0]      din_hold_reg;   // character captured at accept
    logic            key_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            err_reg;
    logic            ready_reg;

    logic [7:0]      ch;             // character after optional case folding
    logic [7:0]      rom;            // {len[2:0], pattern[4:0]}
    logic [2:0]      code_len;
    logic [4:0]      code_pat;
    logic            code_ok;
    logic [2:0]      phase_units;
    logic            unit_end;
    logic            phase_end;

    // Code ROM: length and element pattern, first element in bit len-1, 1 = dash.
    always_comb begin
        ch = din_hold_reg;
`ifdef LOWER_CASE_EN
        if (din_hold_reg >= 8'h61 && din_hold_reg <= 8'h7A) begin
            ch = din_hold_reg - 8'h20;
        end
`endif
        rom = 8'h00;
        case (ch)
            8'h41: rom = {3'd2, 5'b00001};  // A .-
            8'h42: rom = {3'd4, 5'b01000};  // B -...
            8'h43: rom = {3'd4, 5'b01010};  // C -.-.
            8'h44: rom = {3'd3, 5'b00100};  // D -..
            8'h45: rom = {3'd1, 5'b00000};  // E .
            8'h46: rom = {3'd4, 5'b00010};  // F ..-.
            8'h47: rom = {3'd3, 5'b00110};  // G --.
            8'h48: rom = {3'd4, 5'b00000};  // H ....
            8'h49: rom = {3'd2, 5'b00000};  // I ..
            8'h4A: rom = {3'd4, 5'b00111};  // J .---
            8'h4B: rom = {3'd3, 5'b00101};  // K -.-
            8'h4C: rom = {3'd4, 5'b00100};  // L .-..
            8'h4D: rom = {3'd2, 5'b00011};  // M --
            8'h4E: rom = {3'd2, 5'b00010};  // N -.
            8'h4F: rom = {3'd3, 5'b00111};  // O ---
            8'h50: rom = {3'd4, 5'b00110};  // P .--.
            8'h51: rom = {3'd4, 5'b01101};  // Q --.-
            8'h52: rom = {3'd3, 5'b00010};  // R .-.
            8'h53: rom = {3'd3, 5'b00000};  // S ...
            8'h54: rom = {3'd1, 5'b00001};  // T -
            8'h55: rom = {3'd3, 5'b00001};  // U ..-
            8'h56: rom = {3'd4, 5'b00001};  // V ...-
            8'h57: rom = {3'd3, 5'b00011};  // W .--
            8'h58: rom = {3'd4, 5'b01001};  // X -..-
            8'h59: rom = {3'd4, 5'b01011};  // Y -.--
            8'h5A: rom = {3'd4, 5'b01100};  // Z --..
            8'h30: rom = {3'd5, 5'b11111};  // 0 -----
            8'h31: rom = {3'd5, 5'b01111};  // 1 .----
            8'h32: rom = {3'd5, 5'b00111};  // 2 ..---
            8'h33: rom = {3'd5, 5'b00011};  // 3 ...--
            8'h34: rom = {3'd5, 5'b00001};  // 4 ....-
            8'h35: rom = {3'd5, 5'b00000};  // 5 .....
            8'h36: rom = {3'd5, 5'b10000};  // 6 -....
            8'h37: rom = {3'd5, 5'b11000};  // 7 --...
            8'h38: rom = {3'd5, 5'b11100};  // 8 ---..
            8'h39: rom = {3'd5, 5'b11110};  // 9 ----.
            default: rom = 8'h00;
        endcase
    end

    assign code_len = rom[7:5];
    assign code_pat = rom[4:0];
    assign code_ok  = (code_len != 3'd0);

    // Length of the current timed phase, in dot units.
    always_comb begin
        phase_units = 3'd1;
        case (state_reg)
            S_MARK:  phase_units = code_pat[elem_idx_reg] ? 3'd3 : 3'd1;
            S_SPACE: phase_units = 3'd1;
            S_LGAP:  phase_units = 3'd3;
            S_WGAP:  phase_units = 3'd4;
            default: phase_units = 3'd1;
        endcase
    end

    assign unit_end  = (unit_cnt_reg == UNIT_LAST);
    assign phase_end = unit_end && (unit_num_reg == (phase_units - 3'd1));

    // Keyer FSM with unit timing; every output is registered here.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            unit_cnt_reg <= '0;
            unit_num_reg <= 3'd0;
            elem_idx_reg <= 3'd0;
            din_hold_reg <= 8'h00;
            key_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            ready_reg    <= 1'b0;
        end else begin
            err_reg <= 1'b0;

            // The unit counter only runs in the timed states; entry from
            // LOAD clears it so a mark starts on the edge after accept.
            if (state_reg == S_MARK || state_reg == S_SPACE ||
                state_reg == S_LGAP || state_reg == S_WGAP) begin
                if (unit_end) begin
                    unit_cnt_reg <= '0;
                    unit_num_reg <= phase_end ? 3'd0 : (unit_num_reg + 3'd1);
                end else begin
                    unit_cnt_reg <= unit_cnt_reg + 1'b1;
                end
            end

            case (state_reg)
                S_IDLE: begin
                    ready_reg <= 1'b1;
                    if (din_valid && ready_reg) begin
                        din_hold_reg <= din;
                        state_reg    <= S_LOAD;
                        busy_reg     <= 1'b1;
                        ready_reg    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    unit_cnt_reg <= '0;
                    unit_num_reg <= 3'd0;
                    if (din_hold_reg == 8'hFF) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else if (din_hold_reg == 8'h20) begin
                        state_reg <= S_WGAP;
                    end else if (code_ok) begin
                        state_reg    <= S_MARK;
                        key_reg      <= 1'b1;
                        elem_idx_reg <= code_len - 3'd1;
                    end else begin
                        state_reg <= S_IDLE;
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                end
                S_MARK: begin
                    if (phase_end) begin
                        key_reg   <= 1'b0;
                        state_reg <= (elem_idx_reg == 3'd0) ? S_LGAP : S_SPACE;
                    end
                end
                S_SPACE: begin
                    if (phase_end) begin
                        key_reg      <= 1'b1;
                        elem_idx_reg <= elem_idx_reg - 3'd1;
                        state_reg    <= S_MARK;
                    end
                end
                S_LGAP, S_WGAP: begin
                    if (phase_end) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                end
                S_DONE: begin
                    key_reg   <= 1'b0;
                    ready_reg <= 1'b0;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign din_ready = ready_reg;
    assign key_out   = key_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: drives directed and random characters into morse_keyer and
// checks every cycle against a model that expands each accepted byte into the
// output waveform from its dot/dash text. Directed literal checks pin the
// model to hand-computed timings.
module tb_morse_keyer;

    localparam int U    = 50;
    localparam int HMAX = 100000;

    logic       in_clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       key_out;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        logic key;
        logic busy;
        logic ready;
        logic done;
        logic err;
    } exp_t;

    exp_t q[$];
    exp_t exp_cur;
    bit   done_m;

    bit key_hist  [0:HMAX-1];
    bit rdy_hist  [0:HMAX-1];
    bit err_hist  [0:HMAX-1];
    bit done_hist [0:HMAX-1];

    morse_keyer dut (
        .in_clk    (in_clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .key_out   (key_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial in_clk = 1'b0;
    always #10 in_clk = ~in_clk;

    always @(posedge in_clk) cyc <= cyc + 1;

    function automatic string morse_of(input logic [7:0] b);
        logic [7:0] c;
        c = b;
`ifdef LOWER_CASE_EN
        if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
`endif
        case (c)
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";
            "D": return "-..";   "E": return ".";     "F": return "..-.";
            "G": return "--.";   "H": return "....";  "I": return "..";
            "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";
            "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
            "S": return "...";   "T": return "-";     "U": return "..-";
            "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---";
            "3": return "...--"; "4": return "....-"; "5": return ".....";
            "6": return "-...."; "7": return "--..."; "8": return "---..";
            "9": return "----.";
            default: return "";
        endcase
    endfunction

    function automatic exp_t mk(input bit k, input bit b, input bit r, input bit d, input bit e);
        exp_t t;
        t.key = k; t.busy = b; t.ready = r; t.done = d; t.err = e;
        return t;
    endfunction

    // Append the cycle-by-cycle outputs that follow the accept of byte b.
    task automatic expand(input logic [7:0] b);
        string s;
        int    dur;
        q.push_back(mk(0, 1, 0, 0, 0));                 // decode cycle
        if (b == 8'hFF) begin
            done_m = 1'b1;
            return;
        end
        if (b == 8'h20) begin
            repeat (4 * U) q.push_back(mk(0, 1, 0, 0, 0));
            return;
        end
        s = morse_of(b);
        if (s.len() == 0) begin
            q.push_back(mk(0, 0, 1, 0, 1));
            return;
        end
        for (int i = 0; i < s.len(); i++) begin
            dur = (s[i] == "-") ? 3 * U : U;
            repeat (dur) q.push_back(mk(1, 1, 0, 0, 0));
            dur = (i == s.len() - 1) ? 3 * U : U;
            repeat (dur) q.push_back(mk(0, 1, 0, 0, 0));
        end
    endtask

    // Model and per-cycle compare, evaluated mid-cycle.
    initial begin
        exp_t got;
        exp_cur = '0;
        done_m  = 1'b0;
        forever begin
            @(negedge in_clk);
            if (cyc < HMAX) begin
                key_hist[cyc]  = key_out;
                rdy_hist[cyc]  = din_ready;
                err_hist[cyc]  = err;
                done_hist[cyc] = done;
            end
            got = {key_out, busy, din_ready, done, err};
            total++;
            if (!rst) begin
                q.delete();
                done_m  = 1'b0;
                exp_cur = '0;
                if (got !== 5'b0) begin
                    bad++;
                    $display("FAIL reset_outputs cyc=%0d key/busy/rdy/done/err got=%b want=00000", cyc, got);
                end
            end else begin
                if (got !== exp_cur) begin
                    bad++;
                    $display("FAIL cycle_check cyc=%0d key/busy/rdy/done/err got=%b want=%b", cyc, got, exp_cur);
                end
                if (exp_cur.ready && din_valid) expand(din);
                if (q.size() > 0) exp_cur = q.pop_front();
                else              exp_cur = mk(0, 0, !done_m, done_m, 0);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic int key_run(input int from);
        int n;
        n = 0;
        for (int i = from; i < cyc && i < HMAX && key_hist[i] == key_hist[from]; i++) n++;
        return n;
    endfunction

    function automatic int first_ready(input int from);
        for (int i = from; i < cyc && i < HMAX; i++) if (rdy_hist[i]) return i;
        return -1;
    endfunction

    // Present byte b until it is accepted; acc returns the accepting edge.
    task automatic send(input logic [7:0] b, input bit keep, output int acc);
        bit got;
        got = 1'b0;
        acc = 0;
        din = b;
        din_valid = 1'b1;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge in_clk);
            if (din_ready) begin
                @(posedge in_clk);
                #1;
                acc = cyc;
                got = 1'b1;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL send_timeout byte=%h got=no_accept want=accept", b);
        end
        #1;
        if (!keep) din_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge in_clk);
        #2;
    endtask

    function automatic logic [7:0] rand_char();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: return 8'h41 + 8'($urandom_range(0, 25));
            5, 6:          return 8'h30 + 8'($urandom_range(0, 9));
            7:             return 8'h20;
            8:             return 8'h61 + 8'($urandom_range(0, 25));
            default:       return 8'h21 + 8'($urandom_range(0, 14));
        endcase
    endfunction

    initial begin
        #1_800_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        int a2;
        bit ok;
        logic [7:0] c;
        bit keep;

        rst = 1'b1;
        din = 8'h00;
        din_valid = 1'b0;
        #1 rst = 1'b0;
        idle_cycles(3);
        chk("reset_key", key_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_ready", din_ready, 0);
        rst = 1'b1;
        idle_cycles(1);
        chk("ready_after_release", din_ready, 1);

        // Single dot: mark on cycles a+1..a+50, letter gap, ready at a+201.
        send("E", 0, a);
        idle_cycles(260);
        chk("E_no_early_mark", key_hist[a], 0);
        chk("E_mark_level", key_hist[a+1], 1);
        chk("E_mark_len", key_run(a+1), 50);
        chk("E_gap_min", (key_run(a+51) >= 150) ? 1 : 0, 1);
        chk("E_ready_cycle", first_ready(a), a + 201);

        // Dot, space, dash, letter gap.
        send("A", 0, a);
        idle_cycles(450);
        chk("A_dot_len", key_run(a+1), 50);
        chk("A_space_len", key_run(a+51), 50);
        chk("A_dash_level", key_hist[a+101], 1);
        chk("A_dash_len", key_run(a+101), 150);
        chk("A_ready_cycle", first_ready(a), a + 401);

        // "E E" with din_valid held: 3U letter gap + 4U word gap, plus the
        // IDLE and decode cycle at each of the two character boundaries.
        send("E", 1, a);
        send(" ", 1, a2);
        send("E", 0, a2);
        idle_cycles(260);
        chk("EE_space_accept", a2 - a, 404);
        chk("EE_low_between", key_run(a+51), 7 * U + 4);
        chk("EE_second_mark", key_run(a2+1), 50);

        // Lowercase 'a'.
        send(8'h61, 0, a);
        idle_cycles(450);
`ifdef LOWER_CASE_EN
        chk("lc_dot_len", key_run(a+1), 50);
        chk("lc_dash_len", key_run(a+101), 150);
        chk("lc_ready_cycle", first_ready(a), a + 401);
`else
        chk("lc_err_before", err_hist[a], 0);
        chk("lc_err_pulse", err_hist[a+1], 1);
        chk("lc_err_width", err_hist[a+2], 0);
        chk("lc_ready_cycle", first_ready(a), a + 1);
        chk("lc_no_key", (key_run(a) >= 400) ? 1 : 0, 1);
`endif

        // Random stream; the model checks every cycle.
        for (int n = 0; n < 25; n++) begin
            c = rand_char();
            keep = 1'($urandom_range(0, 1));
            send(c, keep, a);
            if (!keep) idle_cycles($urandom_range(0, 3));
        end
        din_valid = 1'b0;
        idle_cycles(1200);

        // Reset in the middle of the dash of 'T', then 'E' keys normally.
        send("T", 0, a);
        idle_cycles(30);
        chk("T_mid_dash", key_out, 1);
        rst = 1'b0;
        #1;
        chk("T_reset_key", key_out, 0);
        chk("T_reset_busy", busy, 0);
        idle_cycles(3);
        rst = 1'b1;
        send("E", 0, a);
        idle_cycles(210);
        chk("E_after_reset_mark", key_run(a+1), 50);
        chk("E_after_reset_ready", first_ready(a), a + 201);

        // Terminator: done next cycle, nothing more accepted or keyed.
        send(8'hFF, 0, a);
        din = "E";
        din_valid = 1'b1;
        idle_cycles(1005);
        chk("FF_done_before", done_hist[a], 0);
        chk("FF_done_next", done_hist[a+1], 1);
        ok = 1'b1;
        for (int i = a + 1; i <= a + 1000; i++)
            if (key_hist[i] || rdy_hist[i] || !done_hist[i]) ok = 1'b0;
        chk("FF_quiet_1000", ok, 1);
        din_valid = 1'b0;
        rst = 1'b0;
        idle_cycles(2);
        chk("done_cleared", done, 0);
        rst = 1'b1;
        idle_cycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
